fifo_ram_packer: RTL
====================

# fifo_ram_packer

Single-clock FIFO with its own inferred simple-dual-port RAM. It packs RATIO narrow write beats into one wide RAM word and adds a selectable read pipeline, occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags. It replaces the controller-less LSRAM wrapper in digitizer sample paths that gather ADC bytes into wide words for downstream DMA.

## Interface
Parameters:
- WWIDTH, 8: write beat width in bits.
- RATIO, 4: write beats per read word, 1..8. RWIDTH = WWIDTH*RATIO.
- DEPTH, 16: RAM depth in read words. Power of two, at least 4.
- PIPE, 1: 0 = RAM output drives RDATA directly; 1 = extra output register stage.
- AFULL_TH, DEPTH-2: AFULL asserted when COUNT >= AFULL_TH.
- AEMPTY_TH, 1: AEMPTY asserted when COUNT <= AEMPTY_TH.

Ports (one clock; reset is asynchronous and active-low):
- CLOCK  in  1  sole clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- WDATA  in  WWIDTH  write beat.
- WE  in  1  write enable.
- RE  in  1  read request.
- RDATA  out  RWIDTH  read word, valid while RVALID=1.
- RVALID  out  1  one-cycle pulse per accepted read.
- FULL, AFULL, EMPTY, AEMPTY  out  1 each  status flags.
- COUNT  out  clog2(DEPTH+1)  committed words held in RAM.
- OVERFLOW, UNDERFLOW  out  1 each  sticky error flags.
- CLR_ERR  in  1  synchronous clear of OVERFLOW and UNDERFLOW.

## Operation
- The write side holds a pack register and a beat index 0..RATIO-1. An accepted beat lands in slice [idx*WWIDTH +: WWIDTH]. Beat 0 occupies the LSBs.
- Write acceptance is WE && !FULL. On the beat with idx = RATIO-1 the word is committed: RAM[wptr] is written, wptr increments, and idx returns to 0. With RATIO=1 every beat commits.
- WE && FULL: the beat is dropped, idx does not change, and OVERFLOW is set.
- Read acceptance is RE && !EMPTY. RAM[rptr] is read and rptr increments. RE && EMPTY sets UNDERFLOW and leaves all other state unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- COUNT: +1 on commit, -1 on accepted read, unchanged when both happen in the same cycle.
- A commit and a read in the same cycle with COUNT=0 cannot occur because EMPTY blocks the read. A commit and a read with COUNT=DEPTH cannot occur because FULL blocks the commit beat.
- Flag decoding: FULL = (COUNT==DEPTH). EMPTY = (COUNT==0). AFULL and AEMPTY follow the thresholds.
- While FULL, a partially filled pack register is held intact.
- A word committed in cycle N is readable from cycle N+1.
- CLR_ERR takes priority over a same-cycle error set: the flag clears.

## Timing
- Reset values: RDATA=0, RVALID=0, COUNT=0, FULL=0, AFULL=0 (AFULL_TH>0), EMPTY=1, AEMPTY=1, OVERFLOW=0, UNDERFLOW=0. Pointers, idx and the pack register are also cleared.
- Reset mid-operation: any partial pack and any reads still in the pipeline are discarded. RVALID falls at once.
- All flags and COUNT are registered and reflect the state after the previous edge.
- Read latency from the RE edge: PIPE=0 gives RDATA/RVALID at +1 cycle; PIPE=1 gives them at +2 cycles.
- Back-to-back reads produce one word per cycle with no bubbles.
- RDATA holds its last value while RVALID=0.

## Structure
- Package fifo_ram_pkg holds the clog2 function and the derived constants RWIDTH_F, AW and CW.
- One sub-module, fifo_ram_sdp: a simple-dual-port synchronous-read RAM with parameters WIDTH and DEPTH, one write port and one read port, and no reset on the array.
- The top level holds the pack logic, pointers, counter, flags and the PIPE generate.

## Test plan
Bench configuration: WWIDTH=8, RATIO=4, DEPTH=16, PIPE=1 unless noted.
- Packing: write 0x11,0x22,0x33,0x44, then RE -> COUNT reaches 1 after the 4th beat. Two cycles after RE, RDATA=0x44332211 with RVALID=1, and COUNT returns to 0.
- Fill: write 64 beats -> FULL=1 and COUNT=16, AFULL=1 from COUNT=14. A 65th beat sets OVERFLOW, and the next read returns the first word unchanged.
- Underflow and clear: RE with EMPTY=1 -> UNDERFLOW=1, RVALID stays 0, COUNT=0. CLR_ERR for 1 cycle -> UNDERFLOW=0.
- Wrap and streaming: continuous writes and reads over 200 words with COUNT held between 2 and 5 -> every word is read back in order, and the pointers wrap at least 12 times.
- Simultaneous events: commit and read in the same cycle at COUNT=3 -> COUNT stays 3. Repeat with PIPE=0 -> RDATA appears 1 cycle after RE.
- Reset mid-stream: assert RESET_N=0 with 2 beats packed and a read in flight -> all outputs take their reset values immediately. After release, a fresh 4-beat write reads back without any stale bytes.

Source files
------------

// File: rtl/fifo_ram_pkg.sv
// Shared sizing helpers for the packing FIFO: ceiling log2 and the widths
// derived from the beat width, pack ratio and RAM depth.
package fifo_ram_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int RWIDTH_F(input int wwidth, input int ratio);
    return wwidth * ratio;
  endfunction

  function automatic int AW(input int depth);
    return clog2(depth);
  endfunction

  // The count must be able to hold DEPTH itself, hence depth+1.
  function automatic int CW(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic int IW(input int ratio);
    return (ratio > 1) ? clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_ram_packer_if.sv
// Bus bundle between a producer/consumer (master) and the packing FIFO (slave).
interface fifo_ram_packer_if #(
  parameter int WWIDTH = 8,
  parameter int RATIO  = 4,
  parameter int DEPTH  = 16
);
  import fifo_ram_pkg::*;

  localparam int RW  = RWIDTH_F(WWIDTH, RATIO);
  localparam int CWL = CW(DEPTH);

  logic [WWIDTH-1:0] WDATA;
  logic              WE;
  logic              RE;
  logic              CLR_ERR;
  logic [RW-1:0]     RDATA;
  logic              RVALID;
  logic              FULL;
  logic              AFULL;
  logic              EMPTY;
  logic              AEMPTY;
  logic [CWL-1:0]    COUNT;
  logic              OVERFLOW;
  logic              UNDERFLOW;

  modport master (
    output WDATA, WE, RE, CLR_ERR,
    input  RDATA, RVALID, FULL, AFULL, EMPTY, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  WDATA, WE, RE, CLR_ERR,
    output RDATA, RVALID, FULL, AFULL, EMPTY, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
  );

endinterface

// File: rtl/fifo_ram_sdp.sv
// Simple-dual-port RAM with registered read; only the read register is reset,
// the array itself is left uninitialised so it maps onto block RAM.
module fifo_ram_sdp
  import fifo_ram_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AWL  = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AWL-1:0]   waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AWL-1:0]   raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Synchronous read; holds its value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_ram_packer.sv
// FIFO that gathers RATIO narrow beats into one wide RAM word, with occupancy
// count, threshold flags, sticky error flags and an optional output register.
module fifo_ram_packer
  import fifo_ram_pkg::*;
#(
  parameter int WWIDTH    = 8,
  parameter int RATIO     = 4,
  parameter int DEPTH     = 16,
  parameter int PIPE      = 1,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 1
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  fifo_ram_packer_if.slave   bus
);

  localparam int RW  = RWIDTH_F(WWIDTH, RATIO);
  localparam int AWL = AW(DEPTH);
  localparam int CWL = CW(DEPTH);
  localparam int IWL = IW(RATIO);

  localparam logic [CWL-1:0] DEPTH_C    = CWL'(DEPTH);
  localparam logic [CWL-1:0] AFULL_C    = CWL'(AFULL_TH);
  localparam logic [CWL-1:0] AEMPTY_C   = CWL'(AEMPTY_TH);
  localparam logic [IWL-1:0] LAST_IDX_C = IWL'(RATIO - 1);
  localparam logic           AFULL_RST_C  = (AFULL_TH <= 0);
  localparam logic           AEMPTY_RST_C = (AEMPTY_TH >= 0);

  logic [IWL-1:0] idx_q, idx_d;
  logic [RW-1:0]  pack_q, pack_d;
  logic [AWL-1:0] wptr_q, wptr_d;
  logic [AWL-1:0] rptr_q, rptr_d;
  logic [CWL-1:0] count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;
  logic           full_q, afull_q, empty_q, aempty_q;
  logic           rv1_q;

  logic           wr_acc_s, commit_s, rd_acc_s;
  logic [RW-1:0]  pack_word_s;
  logic [RW-1:0]  ram_rdata_s;
  logic [RW-1:0]  rdata_out_s;
  logic           rvalid_out_s;

  // Accept decisions use the registered flags, so a full FIFO drops beats
  // and an empty one ignores reads without any combinational path to COUNT.
  always_comb begin
    wr_acc_s = bus.WE && !full_q;
    commit_s = wr_acc_s && (idx_q == LAST_IDX_C);
    rd_acc_s = bus.RE && !empty_q;
  end

  // Merge the incoming beat into its slice of the pack register.
  always_comb begin
    pack_word_s = pack_q;
    for (int b = 0; b < RATIO; b++) begin
      if (idx_q == IWL'(b)) begin
        pack_word_s[b*WWIDTH +: WWIDTH] = bus.WDATA;
      end else begin
        pack_word_s[b*WWIDTH +: WWIDTH] = pack_q[b*WWIDTH +: WWIDTH];
      end
    end
  end

  // Next-state for packing, pointers, occupancy and error flags.
  always_comb begin
    idx_d   = idx_q;
    pack_d  = pack_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    if (commit_s) begin
      idx_d  = '0;
      pack_d = '0;
      wptr_d = wptr_q + 1'b1;
    end else if (wr_acc_s) begin
      idx_d  = idx_q + 1'b1;
      pack_d = pack_word_s;
      wptr_d = wptr_q;
    end else begin
      idx_d  = idx_q;
      pack_d = pack_q;
      wptr_d = wptr_q;
    end

    if (rd_acc_s) begin
      rptr_d = rptr_q + 1'b1;
    end else begin
      rptr_d = rptr_q;
    end

    case ({commit_s, rd_acc_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clearing wins over a same-cycle error.
    if (bus.CLR_ERR) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      ovf_d = ovf_q | (bus.WE && full_q);
      udf_d = udf_q | (bus.RE && empty_q);
    end
  end

  // State and registered status flags.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      idx_q    <= '0;
      pack_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= AFULL_RST_C;
      empty_q  <= 1'b1;
      aempty_q <= AEMPTY_RST_C;
      rv1_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      pack_q   <= pack_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      full_q   <= (count_d == DEPTH_C);
      afull_q  <= (count_d >= AFULL_C);
      empty_q  <= (count_d == {CWL{1'b0}});
      aempty_q <= (count_d <= AEMPTY_C);
      rv1_q    <= rd_acc_s;
    end
  end

  fifo_ram_sdp #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (CLOCK),
    .rst_n   (RESET_N),
    .we_i    (commit_s),
    .waddr_i (wptr_q),
    .wdata_i (pack_word_s),
    .re_i    (rd_acc_s),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata_s)
  );

  if (PIPE != 0) begin : g_pipe
    logic [RW-1:0] rdata_q;
    logic          rv2_q;

    // Extra output stage; captures only on valid so RDATA holds between reads.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
        rdata_q <= '0;
        rv2_q   <= 1'b0;
      end else begin
        rv2_q <= rv1_q;
        if (rv1_q) begin
          rdata_q <= ram_rdata_s;
        end
      end
    end

    assign rdata_out_s  = rdata_q;
    assign rvalid_out_s = rv2_q;
  end else begin : g_nopipe
    assign rdata_out_s  = ram_rdata_s;
    assign rvalid_out_s = rv1_q;
  end

  assign bus.RDATA     = rdata_out_s;
  assign bus.RVALID    = rvalid_out_s;
  assign bus.FULL      = full_q;
  assign bus.AFULL     = afull_q;
  assign bus.EMPTY     = empty_q;
  assign bus.AEMPTY    = aempty_q;
  assign bus.COUNT     = count_q;
  assign bus.OVERFLOW  = ovf_q;
  assign bus.UNDERFLOW = udf_q;

endmodule
